alu_result_stage: RTL and testbench

Registered output stage placed directly downstream of the ALU adder/subtractor. Each cycle it accepts one arithmetic result with its carry or borrow, the original operands and the operation code, and derives the status flags C, V, N and Z. It buffers result and flags in a small FIFO and presents them to the consumer over a valid/ready handshake. It also keeps a sticky overflow indicator for software.

---
 rtl/alu_result_stage.sv | 94 +++++++++
 tb/tb_alu_result_stage.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU result/flag FIFO stage with valid/ready output and sticky overflow
module alu_result_stage #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_op,
  input  logic [7:0]                 in_a,
  input  logic [7:0]                 in_b,
  input  logic [7:0]                 in_result,
  input  logic                       in_cb,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_result,
  output logic [3:0]                 out_flags,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       sticky_ovf,
  input  logic                       clr_sticky
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [11:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_next;
  logic          out_valid_q;
  logic          sticky_q;
  logic          push;
  logic          pop;
  logic          flag_c;
  logic          flag_v;
  logic          flag_n;
  logic          flag_z;
  logic [11:0]   head;

  // Subtract overflows when operand signs differ; add when they match.
  always_comb begin
    flag_z = (in_result == 8'h00);
    flag_n = in_result[7];
    flag_c = in_cb;
    if (in_op)
      flag_v = (in_a[7] != in_b[7]) && (in_result[7] != in_a[7]);
    else
      flag_v = (in_a[7] == in_b[7]) && (in_result[7] != in_a[7]);
  end

  assign in_ready = (level_q != LW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = out_valid_q && out_ready;

  always_comb begin
    level_next = level_q;
    case ({push, pop})
      2'b10:   level_next = level_q + LW'(1);
      2'b01:   level_next = level_q - LW'(1);
      default: level_next = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level_q     <= level_next;
      out_valid_q <= (level_next != '0);
      if (push && flag_v)
        sticky_q <= 1'b1;
      else if (clr_sticky)
        sticky_q <= 1'b0;
    end
  end

  // Storage needs no reset: the head slot is only visible while out_valid is high.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_result, flag_c, flag_v, flag_n, flag_z};
  end

  assign head       = mem[rd_ptr];
  assign out_valid  = out_valid_q;
  assign out_result = out_valid_q ? head[11:4] : 8'h00;
  assign out_flags  = out_valid_q ? head[3:0]  : 4'h0;
  assign level      = level_q;
  assign sticky_ovf = sticky_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed self-checking bench for alu_result_stage
module tb_alu_result_stage;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_op;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [7:0] in_result;
  logic       in_cb;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [3:0] out_flags;
  logic [1:0] level;
  logic       sticky_ovf;
  logic       clr_sticky;

  int passed = 0;
  int total  = 0;

  alu_result_stage #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_result(in_result), .in_cb(in_cb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .level(level), .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r, input logic cb);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_result = r; in_cb = cb;
  endtask

  // Push one vector into an empty stage, check head, then pop it.
  task automatic single(input string tag, input logic op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] r, input logic cb,
                        input logic [3:0] exp_flags);
    out_ready = 1'b0;
    drive(op, a, b, r, cb);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_result"}, out_result, r);
    chk({tag, "_flags"}, out_flags, exp_flags);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_drained"}, level, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 1'b0; in_a = '0; in_b = '0;
    in_result = '0; in_cb = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    #3;
    chk("rst_level", level, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_sticky", sticky_ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    single("sub_5_3", 1'b1, 8'h05, 8'h03, 8'h02, 1'b0, 4'b0000);

    single("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 4'b0100);
    chk("sticky_set", sticky_ovf, 1);
    @(negedge clk);
    chk("sticky_hold", sticky_ovf, 1);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    chk("sticky_clr", sticky_ovf, 0);

    single("sub_00_01", 1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 4'b1010);
    chk("sticky_no_v", sticky_ovf, 0);
    single("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 4'b0110);
    chk("sticky_add_v", sticky_ovf, 1);
    single("sub_3_3", 1'b1, 8'h03, 8'h03, 8'h00, 1'b0, 4'b0001);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;

    // Fill, attempt an overfill, then drain in order.
    out_ready = 1'b0;
    drive(1'b0, 8'h10, 8'h01, 8'h11, 1'b0);
    @(negedge clk);
    chk("fill_level1", level, 1);
    drive(1'b0, 8'h11, 8'h11, 8'h22, 1'b0);
    @(negedge clk);
    chk("fill_level2", level, 2);
    chk("full_in_ready", in_ready, 0);
    drive(1'b0, 8'h11, 8'h22, 8'h33, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("overfill_level", level, 2);
    chk("overfill_head", out_result, 8'h11);
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_head2", out_result, 8'h22);
    chk("drain_in_ready", in_ready, 1);
    chk("drain_level1", level, 1);
    @(negedge clk);
    chk("drain_level0", level, 0);
    chk("drain_valid0", out_valid, 0);
    chk("drain_no_dup", out_result, 0);

    // Streaming push+pop at level 1 across pointer wraps.
    out_ready = 1'b0;
    drive(1'b0, 8'h01, 8'h00, 8'h01, 1'b0);
    @(negedge clk);
    for (int i = 2; i <= 7; i++) begin
      chk($sformatf("stream_head_%0d", i - 1), out_result, i - 1);
      chk($sformatf("stream_level_%0d", i - 1), level, 1);
      if (i <= 6) drive(1'b0, 8'(i), 8'h00, 8'(i), 1'b0);
      else in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("stream_empty", level, 0);

    // Asynchronous reset mid-stream.
    drive(1'b1, 8'h80, 8'h01, 8'h7F, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h01, 8'h01, 8'h02, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_level", level, 2);
    chk("pre_rst_sticky", sticky_ovf, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_level", level, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_result", out_result, 0);
    chk("mid_rst_sticky", sticky_ovf, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Set wins over clear in the same cycle.
    out_ready = 1'b1;
    clr_sticky = 1'b1;
    drive(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    clr_sticky = 1'b0;
    chk("set_over_clr", sticky_ovf, 1);
    chk("set_over_clr_flags", out_flags, 4'b0110);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    chk("clr_after", sticky_ovf, 0);
    chk("final_level", level, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
